// File: rtl/tx_fifo_pkg.sv
// Shared constants and helpers for the tx_fifo block.
// Word/depth defaults, the level-width helper and the drop-counter saturation value.
package tx_fifo_pkg;

    localparam int TX_WORD_W     = 32;
    localparam int TX_FIFO_DEPTH = 1024;
    localparam logic [31:0] DROP_SAT = 32'hFFFF_FFFF;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tx_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Written without reset so it maps onto block RAM.
module tx_fifo_ram #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 1023,
    parameter int AW      = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tx_fifo.sv
// First-word-fall-through FIFO: DEPTH-1 RAM words plus one head register, overruns dropped.
// Optional statistics (drop_count, max_level) are built only when TX_FIFO_STATS_EN is defined.
module tx_fifo
    import tx_fifo_pkg::*;
#(
    parameter int WIDTH = TX_WORD_W,
    parameter int DEPTH = TX_FIFO_DEPTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [clog2(DEPTH):0] level,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [31:0]           drop_count,
    output logic [clog2(DEPTH):0] max_level
);

    localparam int AW      = clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int ENTRIES = DEPTH - 1;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 2);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // Handshake: the head word transfers on any edge where rd_valid & rd_ready; rd_valid never
    // depends on rd_ready. The write side has no backpressure: wr_en while full drops the word.

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             head_valid;
    logic             head_from_ram;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] ram_q;
    logic [LW-1:0]    ram_count;
    logic [LW-1:0]    level_next;
    logic             pop;
    logic             accept;
    logic             drop;
    logic             head_free;
    logic             ram_empty;
    logic             load_ram;
    logic             bypass;
    logic             ram_we;

    // RAM depth is not a power of two, so pointers wrap by compare-and-reset.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
    endfunction

    assign pop        = head_valid & rd_ready;
    assign accept     = wr_en & ~full;
    assign drop       = wr_en & full;
    assign head_free  = ~head_valid | pop;
    assign ram_count  = level - LW'(head_valid);
    assign ram_empty  = (ram_count == '0);
    assign load_ram   = head_free & ~ram_empty;
    assign bypass     = head_free & ram_empty & accept;
    assign ram_we     = accept & ~bypass;
    assign level_next = level + LW'(accept) - LW'(pop);

    tx_fifo_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_ram (
        .clk   (clk_in),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (load_ram),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            head_valid    <= 1'b0;
            head_from_ram <= 1'b0;
            head_q        <= '0;
            level         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            overflow      <= 1'b0;
        end else begin
            if (ram_we) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (load_ram) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            if (head_free) begin
                head_valid <= load_ram | bypass;
            end
            // The head word lives either in the RAM read register or in head_q (bypass).
            if (load_ram) begin
                head_from_ram <= 1'b1;
            end else if (bypass) begin
                head_from_ram <= 1'b0;
                head_q        <= wr_data;
            end
            level <= level_next;
            full  <= (level_next == FULL_LEVEL);
            empty <= (level_next == '0);
            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign rd_valid = head_valid;
    assign rd_data  = head_from_ram ? ram_q : head_q;

`ifdef TX_FIFO_STATS_EN
    logic [31:0]   drop_q;
    logic [LW-1:0] max_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            drop_q <= '0;
            max_q  <= '0;
        end else if (ovf_clr) begin
            drop_q <= '0;
            max_q  <= level;
        end else begin
            if (drop && (drop_q != DROP_SAT)) begin
                drop_q <= drop_q + 32'd1;
            end
            if (level > max_q) begin
                max_q <= level;
            end
        end
    end

    assign drop_count = drop_q;
    assign max_level  = max_q;
`else
    assign drop_count = '0;
    assign max_level  = '0;
`endif

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_tx_fifo;

    localparam int W     = 32;
    localparam int DEPTH = 512;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_in;
    logic          rst_in;
    logic [W-1:0]  wr_data;
    logic          wr_en;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          ovf_clr;
    logic [31:0]   drop_count;
    logic [LW-1:0] max_level;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [W-1:0] exp_q[$];
    logic         m_ovf;
    logic [31:0]  m_drops;
    int           m_max;

    tx_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .drop_count (drop_count),
        .max_level  (max_level)
    );

    // Clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_drops = '0;
        m_max   = 0;
    endtask

    task automatic do_reset();
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        rst_in   = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        model_reset();
    endtask

    // Spec rules applied to a word queue: accept only when not full (before the pop),
    // pop when the queue has a head and the consumer is ready.
    task automatic model_step(input logic we, input logic [W-1:0] wd, input logic rr,
                              input logic clr);
        int  sz;
        bit  is_full;
        bit  do_pop;
        sz      = exp_q.size();
        is_full = (sz == DEPTH);
        do_pop  = rr && (sz > 0);
        if (clr) begin
            m_ovf   = 1'b0;
            m_drops = '0;
            m_max   = sz;
        end else begin
            if (sz > m_max) m_max = sz;
            if (we && is_full) begin
                m_ovf = 1'b1;
                if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
            end
        end
        if (do_pop) void'(exp_q.pop_front());
        if (we && !is_full) exp_q.push_back(wd);
    endtask

    // Driver: inputs change 1 time unit after an edge; outputs are sampled at the same point.
    task automatic tick(input logic we, input logic [W-1:0] wd, input logic rr, input logic clr);
        wr_en    = we;
        wr_data  = wd;
        rd_ready = rr;
        ovf_clr  = clr;
        @(posedge clk_in);
        model_step(we, wd, rr, clr);
        #1;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = exp_q.size();
        chk({tag, "_valid"}, 64'(rd_valid), 64'(sz > 0));
        chk({tag, "_level"}, 64'(level), 64'(sz));
        chk({tag, "_full"}, 64'(full), 64'(sz == DEPTH));
        chk({tag, "_empty"}, 64'(empty), 64'(sz == 0));
        chk({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
        if (sz > 0) chk({tag, "_data"}, 64'(rd_data), 64'(exp_q[0]));
`ifdef TX_FIFO_STATS_EN
        chk({tag, "_drops"}, 64'(drop_count), 64'(m_drops));
        chk({tag, "_max"}, 64'(max_level), 64'(m_max));
`else
        chk({tag, "_drops"}, 64'(drop_count), 64'd0);
        chk({tag, "_max"}, 64'(max_level), 64'd0);
`endif
    endtask

    typedef struct {
        logic          we;
        logic [W-1:0]  wd;
        logic          rr;
        logic          clr;
        logic [LW-1:0] lvl;
        logic          vld;
        logic [W-1:0]  data;
        logic          fl;
        logic          em;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int sent;
        int max_seen;
        logic [31:0] exp_drops;
        logic [31:0] exp_max;
        n_checks = 0;
        n_errors = 0;
        rst_in   = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        model_reset();

        // Reset state
        do_reset();
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drops", 64'(drop_count), 64'd0);
        chk("rst_max", 64'(max_level), 64'd0);

        // Vector table: small handshake sequence including the bypass path
        vecs[0] = '{1'b1, 32'h11, 1'b0, 1'b0, LW'(1), 1'b1, 32'h11, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h22, 1'b0, 1'b0, LW'(2), 1'b1, 32'h11, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h33, 1'b1, 1'b0, LW'(2), 1'b1, 32'h22, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b0, LW'(1), 1'b1, 32'h33, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b0, LW'(0), 1'b0, 32'h00, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'h44, 1'b1, 1'b0, LW'(1), 1'b1, 32'h44, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h55, 1'b1, 1'b0, LW'(1), 1'b1, 32'h55, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h00, 1'b0, 1'b1, LW'(1), 1'b1, 32'h55, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].we, vecs[i].wd, vecs[i].rr, vecs[i].clr);
            chk($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].lvl));
            chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].vld));
            chk($sformatf("vec%0d_full", i), 64'(full), 64'(vecs[i].fl));
            chk($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].em));
            if (vecs[i].vld) chk($sformatf("vec%0d_data", i), 64'(rd_data), 64'(vecs[i].data));
        end

        // Fill with 2*DEPTH words, no reads: half are dropped
        do_reset();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            tick(1'b1, W'(i), 1'b0, 1'b0);
            check_model("fill");
        end
        chk("fill_level", 64'(level), 64'(DEPTH));
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_overflow", 64'(overflow), 64'd1);
`ifdef TX_FIFO_STATS_EN
        exp_drops = 32'(DEPTH);
        exp_max   = 32'(DEPTH);
`else
        exp_drops = 32'd0;
        exp_max   = 32'd0;
`endif
        chk("fill_drops", 64'(drop_count), 64'(exp_drops));
        chk("fill_max", 64'(max_level), 64'(exp_max));
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 64'(rd_data), 64'(i));
            tick(1'b0, '0, 1'b1, 1'b0);
            check_model("drain");
        end
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_valid", 64'(rd_valid), 64'd0);

        // Simultaneous pop and write at full: write dropped
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, W'(i), 1'b0, 1'b0);
        check_model("prefull");
        tick(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        chk("fullrw_level", 64'(level), 64'(DEPTH - 1));
        chk("fullrw_full", 64'(full), 64'd0);
        chk("fullrw_head", 64'(rd_data), 64'd1);
        chk("fullrw_overflow", 64'(overflow), 64'd1);
`ifdef TX_FIFO_STATS_EN
        chk("fullrw_drops", 64'(drop_count), 64'd1);
`endif
        check_model("fullrw");

        // ovf_clr in the same cycle as a drop: clear wins
        tick(1'b1, 32'h0000_F00D, 1'b0, 1'b0);
        chk("refill_full", 64'(full), 64'd1);
        tick(1'b1, 32'h0000_BAD0, 1'b0, 1'b1);
        chk("clr_overflow", 64'(overflow), 64'd0);
        chk("clr_drops", 64'(drop_count), 64'd0);
`ifdef TX_FIFO_STATS_EN
        chk("clr_max", 64'(max_level), 64'(DEPTH));
`endif
        check_model("clr");
        tick(1'b0, '0, 1'b0, 1'b0);
        check_model("postclr");

        // Streaming with rd_ready held high
        do_reset();
        max_seen = 0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            tick(1'b1, W'(i), 1'b1, 1'b0);
            chk("stream_word", 64'(rd_data), 64'(i));
            if (int'(level) > max_seen) max_seen = int'(level);
            check_model("stream");
        end
        chk("stream_level_le2", 64'(max_seen <= 2), 64'd1);
        chk("stream_overflow", 64'(overflow), 64'd0);
`ifdef TX_FIFO_STATS_EN
        chk("stream_max_le2", 64'(max_level <= LW'(2)), 64'd1);
`endif

        // Random traffic across several pointer wraps
        do_reset();
        sent = 0;
        while (sent < 3 * DEPTH) begin
            logic we;
            logic rr;
            we = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            tick(we, $urandom, rr, 1'($urandom_range(0, 63) == 0));
            if (we) sent++;
            check_model("wrap");
        end
        for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) begin
            tick(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
            check_model("wrapdrain");
        end
        chk("wrap_empty", 64'(empty), 64'd1);

        // Asynchronous reset in the middle of an overflowing burst
        do_reset();
        for (int i = 0; i < DEPTH + 8; i++) tick(1'b1, W'(i), 1'b0, 1'b0);
        chk("prerst_overflow", 64'(overflow), 64'd1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_valid", 64'(rd_valid), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        wr_en = 1'b0;
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 32'hA000_0000 + W'(i), 1'b1, 1'b0);
            if (i == 0) chk("arst_first_word", 64'(rd_data), 64'hA000_0000);
            check_model("postrst");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
